fir_serial_mac: RTL and testbench
=================================

Name: fir_serial_mac

Overview:
- Time-multiplexed (single-multiplier) FIR filter.
- Sits directly downstream of the ROM-based test-signal source and consumes its 12-bit sample stream.
- Holds a TAPS-deep sample delay line and a register-loadable coefficient table.
- Produces one full-precision signed output per accepted sample, with a valid/ready handshake on the input side.

Parameters:
- TAPS, 16, number of filter taps; power of two, 2..64.
- DIN_W, 12, input sample width.
- COEF_W, 12, signed coefficient width.
- DOUT_W, 28, output width = DIN_W+COEF_W+log2(TAPS); full precision, never truncated.

Ports:
- sys_clk  in  1  single clock; all logic on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- din  in  DIN_W  input sample; signed two's complement unless OFFSET_BIN_EN.
- din_valid  in  1  din is valid.
- din_ready  out  1  block can accept a sample this cycle.
- coef_wr_en  in  1  coefficient write strobe.
- coef_wr_addr  in  log2(TAPS)  tap index being written.
- coef_wr_data  in  COEF_W  signed coefficient value.
- dout  out  DOUT_W  signed filter output, registered.
- dout_valid  out  1  one-cycle pulse; dout is new.

Interface decision: one clock, sys_clk; reset sys_rst is synchronous and active-high.

Behaviour:
- Reset values: dout=0, dout_valid=0, din_ready=1 (state IDLE).
  - All delay-line registers are cleared to 0.
  - All coefficients are cleared to 0.
  - Write pointer wp=0, tap counter k=0, accumulator acc=0.
- Storage:
  - Delay line is a circular buffer of TAPS registers.
  - Newest sample is at wp; tap k reads x[(wp-k) mod TAPS].
  - Pointer arithmetic wraps naturally in log2(TAPS) bits.
- State IDLE:
  - din_ready=1.
  - On din_valid&&din_ready, at the same edge:
    - wp<=wp+1 and the sample is written at wp+1.
    - acc<=0, k<=0, state<=MAC.
  - No acceptance means no state change.
- State MAC:
  - din_ready=0.
  - Each cycle: product = x[(wp-k) mod TAPS]*h[k], signed DIN_W x COEF_W, full width, sign-extended to DOUT_W.
  - k<TAPS-1: acc<=acc+product, k<=k+1.
  - k==TAPS-1: dout<=acc+product, dout_valid<=1, state<=IDLE.
  - Exactly TAPS MAC cycles per sample; no overflow possible at DOUT_W.
- Timing:
  - Latency: dout_valid is high in the cycle following the TAPS-th edge after the accepting edge.
  - din_ready rises in that same cycle.
  - Throughput: one sample per TAPS+1 cycles when din_valid is held high.
- dout_valid is a single-cycle pulse; dout holds its value until the next result.
- Coefficient writes:
  - Accepted only while state==IDLE; ignored (silently dropped) during MAC.
  - A write coincident with a sample acceptance is applied; that sample's MAC uses the new value.
  - Writes to the same address overwrite.
- din is ignored whenever din_ready=0; upstream holds din/din_valid until accepted.
- Reset asserted mid-MAC aborts the computation; no dout_valid is produced; everything returns to reset values the next cycle.

Optional Feature:
- Macro: FIR_OFFSET_BIN_EN.
- Defined: din is interpreted as unsigned offset-binary (0..2^DIN_W-1, midscale 2^(DIN_W-1)). It is converted to signed by inverting the MSB before storing in the delay line, so 12'h800 maps to 0, 12'h000 to -2048, and 12'hFFF to +2047.
- Undefined: din is stored as-is, as two's complement.
- Both variants use the same ports and the same latency.

Test Plan:
- Impulse, macro off: h[k]=k+1 (k=0..15); din=1 then 20 zeros, din_valid held high. Required dout sequence: 1,2,...,16,0,0,...; dout_valid pulses every 17 cycles.
- Step: all h=1; din=100 continuously. Required dout: 100,200,...,1600, then 1600 steady.
- Extreme: all h=-2048, din=-2048 for 16 samples. Required 16th dout=67108864 (2^26), with no wrap at 28 bits.
- Coefficient write during MAC: write h[0]=5 while din_ready=0. Required: write is ignored; a following impulse response starts with the old h[0].
- Reset mid-MAC: assert sys_rst at the 5th MAC cycle for 1 cycle. Required: no dout_valid; dout=0; din_ready=1 the next cycle; the delay line reads as zeros on a subsequent impulse.
- Macro on: h[0]=1, others 0; din=12'h800, then 12'h000, then 12'hFFF. Required dout: 0, -2048, +2047.

Source files
------------

// File: rtl/fir_serial_mac.sv
// Time-multiplexed FIR filter with a single multiplier.
// One accepted sample starts TAPS multiply-accumulate cycles over a circular delay line;
// the full-precision sum is registered on dout with a one-cycle dout_valid pulse.
// Build option: define FIR_OFFSET_BIN_EN to treat din as offset-binary (MSB inverted on entry).
module fir_serial_mac #(
   parameter int unsigned TAPS   = 16,
   parameter int unsigned DIN_W  = 12,
   parameter int unsigned COEF_W = 12,
   parameter int unsigned DOUT_W = 28
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst,
   input  logic [DIN_W-1:0]          din,
   input  logic                      din_valid,
   output logic                      din_ready,
   input  logic                      coef_wr_en,
   input  logic [$clog2(TAPS)-1:0]   coef_wr_addr,
   input  logic [COEF_W-1:0]         coef_wr_data,
   output logic [DOUT_W-1:0]         dout,
   output logic                      dout_valid
);

   localparam int unsigned AW = $clog2(TAPS);
   localparam int unsigned PW = DIN_W + COEF_W;
   localparam logic [AW-1:0] KLast = AW'(TAPS - 1);

   typedef enum logic [0:0] {StIdle, StMac} state_e;

   state_e                   state_q, state_d;
   logic [AW-1:0]            wp_q, k_q;
   logic [AW-1:0]            wp_inc, rd_idx;
   logic signed [DIN_W-1:0]  x_q [TAPS];
   logic signed [COEF_W-1:0] h_q [TAPS];
   logic signed [DOUT_W-1:0] acc_q;
   logic signed [PW-1:0]     prod;
   logic signed [DOUT_W-1:0] prod_ext;
   logic signed [DOUT_W-1:0] sum;
   logic [DIN_W-1:0]         din_conv;
   logic                     accept;
   logic                     k_last;

`ifdef FIR_OFFSET_BIN_EN
   // Offset-binary to two's complement: midscale maps to zero.
   assign din_conv = {~din[DIN_W-1], din[DIN_W-2:0]};
`else
   assign din_conv = din;
`endif

   assign wp_inc   = wp_q + 1'b1;
   assign rd_idx   = wp_q - k_q;  // wraps naturally in AW bits
   assign k_last   = (k_q == KLast);
   assign prod     = x_q[rd_idx] * h_q[k_q];
   assign prod_ext = {{(DOUT_W - PW){prod[PW-1]}}, prod};
   assign sum      = acc_q + prod_ext;

   // State register.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) state_q <= StIdle;
      else         state_q <= state_d;
   end

   // Next-state decode and handshake outputs.
   always_comb begin
      state_d   = state_q;
      din_ready = 1'b0;
      accept    = 1'b0;
      unique case (state_q)
         StIdle: begin
            din_ready = 1'b1;
            if (din_valid) begin
               accept  = 1'b1;
               state_d = StMac;
            end
         end
         StMac: begin
            if (k_last) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Delay line and coefficient table; coefficient writes only land while idle.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         for (int i = 0; i < int'(TAPS); i++) begin
            x_q[i] <= '0;
            h_q[i] <= '0;
         end
      end else begin
         if (accept) x_q[wp_inc] <= din_conv;
         if (state_q == StIdle && coef_wr_en) h_q[coef_wr_addr] <= coef_wr_data;
      end
   end

   // Pointer, tap counter, accumulator and registered output.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         wp_q       <= '0;
         k_q        <= '0;
         acc_q      <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
      end else begin
         dout_valid <= 1'b0;
         if (accept) begin
            wp_q  <= wp_inc;
            k_q   <= '0;
            acc_q <= '0;
         end else if (state_q == StMac) begin
            if (k_last) begin
               dout       <= sum;
               dout_valid <= 1'b1;
            end else begin
               acc_q <= sum;
               k_q   <= k_q + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fir_serial_mac.sv
// Self-checking bench for fir_serial_mac: constant vector tables, hand-written corner
// sequences, and randomized traffic checked against a convolution model over sample history.
module tb_fir_serial_mac;

   localparam int TAPS   = 16;
   localparam int DIN_W  = 12;
   localparam int COEF_W = 12;
   localparam int DOUT_W = 28;
   localparam int AW     = 4;

   logic              sys_clk = 1'b0;
   logic              sys_rst;
   logic [DIN_W-1:0]  din;
   logic              din_valid;
   logic              din_ready;
   logic              coef_wr_en;
   logic [AW-1:0]     coef_wr_addr;
   logic [COEF_W-1:0] coef_wr_data;
   logic [DOUT_W-1:0] dout;
   logic              dout_valid;

   int vectors = 0;
   int miscompares = 0;

   // Model state: every accepted sample (as a signed value) and the coefficient table.
   int hist[$];
   int h_m[TAPS];

   typedef struct {
      int     sval;
      longint exp;
   } vec_t;
   vec_t tbl[$];

   fir_serial_mac #(
      .TAPS  (TAPS),
      .DIN_W (DIN_W),
      .COEF_W(COEF_W),
      .DOUT_W(DOUT_W)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .din         (din),
      .din_valid   (din_valid),
      .din_ready   (din_ready),
      .coef_wr_en  (coef_wr_en),
      .coef_wr_addr(coef_wr_addr),
      .coef_wr_data(coef_wr_data),
      .dout        (dout),
      .dout_valid  (dout_valid)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Raw input code to the signed value it represents.
   function automatic int conv(input logic [DIN_W-1:0] raw);
`ifdef FIR_OFFSET_BIN_EN
      return int'({1'b0, raw}) - 2048;
`else
      return int'($signed(raw));
`endif
   endfunction

   // Signed value to the raw input code that represents it.
   function automatic logic [DIN_W-1:0] encode(input int v);
      int t;
`ifdef FIR_OFFSET_BIN_EN
      t = v + 2048;
`else
      t = v;
`endif
      return t[DIN_W-1:0];
   endfunction

   function automatic longint model_out();
      longint s = 0;
      for (int k = 0; k < TAPS; k++) begin
         int idx = hist.size() - 1 - k;
         if (idx >= 0) s += longint'(h_m[k]) * longint'(hist[idx]);
      end
      return s;
   endfunction

   task automatic check(input string name, input longint got, input longint exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      tick();
      tick();
      sys_rst = 1'b0;
      hist.delete();
      for (int i = 0; i < TAPS; i++) h_m[i] = 0;
   endtask

   // Only called while the block is idle.
   task automatic write_coef(input int a, input int v);
      coef_wr_en   = 1'b1;
      coef_wr_addr = a[AW-1:0];
      coef_wr_data = v[COEF_W-1:0];
      tick();
      coef_wr_en = 1'b0;
      h_m[a] = int'($signed(v[COEF_W-1:0]));
   endtask

   // Offer one sample (optionally with a coincident coefficient write), wait for its result.
   task automatic run_sample(input logic [DIN_W-1:0] raw, output longint got,
                             input bit wr = 1'b0, input int wa = 0, input int wv = 0);
      int     w;
      int     cyc;
      longint exp;
      din       = raw;
      din_valid = 1'b1;
      w = 0;
      while (!din_ready && w < 100) begin
         tick();
         w++;
      end
      check("accept_timeout", longint'(w < 100), 1);
      if (wr) begin
         coef_wr_en   = 1'b1;
         coef_wr_addr = wa[AW-1:0];
         coef_wr_data = wv[COEF_W-1:0];
         h_m[wa] = int'($signed(wv[COEF_W-1:0]));
      end
      hist.push_back(conv(raw));
      exp = model_out();
      tick();
      din_valid  = 1'b0;
      coef_wr_en = 1'b0;
      din        = DIN_W'($urandom);
      cyc = 0;
      do begin
         tick();
         cyc++;
         // While busy, a stray valid must not be accepted.
         if (!dout_valid && cyc == 3) din_valid = 1'b1;
      end while (!dout_valid && cyc < 50);
      din_valid = 1'b0;
      check("latency", cyc, TAPS);
      check("ready_with_result", din_ready, 1);
      got = longint'($signed(dout));
      check("dout_vs_model", got, exp);
   endtask

   initial begin
      longint got;
      longint held;
      int     seen;

      sys_rst      = 1'b1;
      din          = '0;
      din_valid    = 1'b0;
      coef_wr_en   = 1'b0;
      coef_wr_addr = '0;
      coef_wr_data = '0;
      do_reset();

      // Reset state.
      check("reset_dout", longint'(dout), 0);
      check("reset_dout_valid", dout_valid, 0);
      check("reset_din_ready", din_ready, 1);

      // Impulse: h[k]=k+1, din=1 then 20 zeros.
      for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
      tbl.delete();
      tbl.push_back('{sval: 1, exp: 1});
      for (int i = 1; i <= 20; i++) tbl.push_back('{sval: 0, exp: (i < TAPS) ? i + 1 : 0});
      foreach (tbl[i]) begin
         run_sample(encode(tbl[i].sval), got);
         check("impulse", got, tbl[i].exp);
      end
      // Pulse is one cycle wide and dout holds.
      held = got;
      tick();
      check("pulse_width", dout_valid, 0);
      check("dout_hold", longint'($signed(dout)), held);

      // Step: all h=1, din=100.
      do_reset();
      for (int k = 0; k < TAPS; k++) write_coef(k, 1);
      tbl.delete();
      for (int i = 0; i < 20; i++) tbl.push_back('{sval: 100, exp: 100 * ((i < TAPS) ? i + 1 : TAPS)});
      foreach (tbl[i]) begin
         run_sample(encode(tbl[i].sval), got);
         check("step", got, tbl[i].exp);
      end

      // Extreme: h=-2048, din=-2048; 16th result is 2^26.
      do_reset();
      for (int k = 0; k < TAPS; k++) write_coef(k, -2048);
      tbl.delete();
      for (int i = 0; i < TAPS; i++) tbl.push_back('{sval: -2048, exp: longint'(i + 1) * 4194304});
      foreach (tbl[i]) begin
         run_sample(encode(tbl[i].sval), got);
         check("extreme", got, tbl[i].exp);
      end
      check("extreme_final", got, 67108864);

      // Coefficient write during MAC is dropped.
      do_reset();
      for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
      din       = encode(0);
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      hist.push_back(0);
      tick();
      tick();
      check("busy_ready_low", din_ready, 0);
      coef_wr_en   = 1'b1;
      coef_wr_addr = '0;
      coef_wr_data = 12'd5;
      tick();
      coef_wr_en = 1'b0;
      seen = 0;
      while (!dout_valid && seen < 40) begin
         tick();
         seen++;
      end
      check("mac_write_done", longint'(dout_valid), 1);
      run_sample(encode(1), got);
      check("mac_write_ignored", got, 1);

      // Write coincident with acceptance is applied to that sample.
      run_sample(encode(2), got, 1'b1, 0, 3);
      check("coincident_write", got, 3 * 2 + 2 * 1);

      // Reset in the 5th MAC cycle aborts and clears everything.
      do_reset();
      for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
      for (int i = 7; i <= 9; i++) run_sample(encode(i), got);
      din       = encode(10);
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      sys_rst = 1'b1;
      tick();
      sys_rst = 1'b0;
      check("midrst_dout_valid", dout_valid, 0);
      check("midrst_dout", longint'(dout), 0);
      check("midrst_din_ready", din_ready, 1);
      hist.delete();
      for (int i = 0; i < TAPS; i++) h_m[i] = 0;
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         if (dout_valid) seen++;
         tick();
      end
      check("midrst_no_valid", seen, 0);
      run_sample(encode(5), got);
      check("midrst_coefs_cleared", got, 0);
      for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
      run_sample(encode(1), got);
      check("midrst_line_cleared", got, 1 * 1 + 2 * 5);

      // Input format: h[0]=1, others 0.
      do_reset();
      write_coef(0, 1);
      run_sample(12'h800, got);
`ifdef FIR_OFFSET_BIN_EN
      check("fmt_800", got, 0);
`else
      check("fmt_800", got, -2048);
`endif
      run_sample(12'h000, got);
`ifdef FIR_OFFSET_BIN_EN
      check("fmt_000", got, -2048);
`else
      check("fmt_000", got, 0);
`endif
      run_sample(12'hFFF, got);
`ifdef FIR_OFFSET_BIN_EN
      check("fmt_fff", got, 2047);
`else
      check("fmt_fff", got, -1);
`endif

      // Randomized traffic with idle gaps and coefficient updates.
      do_reset();
      for (int k = 0; k < TAPS; k++) write_coef(k, int'($signed(COEF_W'($urandom))));
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 2) == 0)
            write_coef($urandom_range(0, TAPS - 1), int'($signed(COEF_W'($urandom))));
         for (int g = $urandom_range(0, 3); g > 0; g--) tick();
         if ($urandom_range(0, 4) == 0)
            run_sample(DIN_W'($urandom), got, 1'b1, $urandom_range(0, TAPS - 1),
                       int'($signed(COEF_W'($urandom))));
         else
            run_sample(DIN_W'($urandom), got);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
